// File: rtl/imem_pkg.sv
// imem_pkg: shared types for the instruction-memory responder.
// Response bundle carried from the s1 stage through the response FIFO.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;

  localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0]            addr;
    logic [IMEM_DATA_W-1:0] instr;
    logic                   err;
  } rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: small in-order FIFO of rsp_t with push/pop/clear.
// Head is read straight out of the registered entry array.
module resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  rsp_t          i_din,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [CW-1:0] o_count,
  output rsp_t          o_head
);

  rsp_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; data needs no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_din;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: loadable instruction array with registered read,
// s1 stage and credit-limited in-order response FIFO.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              flush
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              r_s1_valid;
  rsp_t              r_s1;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  rsp_t          w_head;
  logic          w_acc;
  logic          w_oor;
  logic          w_pop;

  // In-flight work is s1 plus queued entries; this bounds acceptance.
  assign w_occ     = w_count + CW'(r_s1_valid);
  assign req_ready = !flush && (w_occ < CW'(FIFO_DEPTH));
  assign w_acc     = req_valid && req_ready;
  assign w_oor     = |req_addr[31:ADDR_W];

  // Array write and s1 capture; old word wins on same-index collision.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
    if (w_acc) begin
      r_s1.addr  <= req_addr;
      r_s1.err   <= w_oor;
      r_s1.instr <= w_oor ? NOP_INSTR
                          : r_mem[req_addr[ADDR_W-1:0]];
    end
  end

  // s1 occupancy; every valid s1 moves into the FIFO next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_acc;
    end
  end

  assign rsp_valid = (w_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_s1_valid),
    .i_din   (r_s1),
    .i_pop   (w_pop),
    .i_clear (flush),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign rsp_instr = rsp_valid ? w_head.instr : '0;
  assign rsp_addr  = rsp_valid ? w_head.addr  : '0;
  assign rsp_err   = rsp_valid ? w_head.err   : 1'b0;

endmodule
